// File: rtl/ctrl_queue_push_arbiter.sv
// Round-robin arbiter sharing the control queue push port between NUM_REQ requesters.
// Grants are zero-latency: grant, push and pushedData follow req combinationally.
// A requester can lock the arbiter so that its multi-word command reaches the queue
// without words from other requesters in between.

`ifndef PS_PL_CTRL_QUEUE_DATA_BIT_SIZE
`define PS_PL_CTRL_QUEUE_DATA_BIT_SIZE 32
`endif

module ctrl_queue_push_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_WIDTH    = `PS_PL_CTRL_QUEUE_DATA_BIT_SIZE,
  parameter int unsigned REQ_IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          queueFull,
  output logic                          push,
  output logic [DATA_WIDTH-1:0]         pushedData,
  output logic                          locked,
  output logic [REQ_IDX_WIDTH-1:0]      owner
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                   state_q;
  logic [REQ_IDX_WIDTH-1:0] rr_ptr_q;
  logic [REQ_IDX_WIDTH-1:0] owner_q;

  logic                     win_found;
  logic [REQ_IDX_WIDTH-1:0] win_idx;
  int unsigned              scan_idx;
  logic [REQ_IDX_WIDTH-1:0] cand_idx;

  logic                     sel_valid;
  logic [REQ_IDX_WIDTH-1:0] sel_idx;
  logic                     sel_lock;
  logic                     accept;
  logic [REQ_IDX_WIDTH-1:0] next_ptr;

  // Round-robin scan starting at rr_ptr_q; first requesting index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      cand_idx = REQ_IDX_WIDTH'(scan_idx);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Candidate selection: round-robin winner when idle, only the owner when locked.
  always_comb begin
    if (state_q == StLocked) begin
      sel_valid = req[owner_q];
      sel_idx   = owner_q;
    end else begin
      sel_valid = win_found;
      sel_idx   = win_idx;
    end
    accept   = sel_valid && !queueFull;
    next_ptr = (sel_idx == REQ_IDX_WIDTH'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
  end

  // Output mux: one-hot grant, push strobe and forwarded word (zero when nothing accepted).
  always_comb begin
    grant      = '0;
    pushedData = '0;
    sel_lock   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == REQ_IDX_WIDTH'(i)) begin
        sel_lock = lock[i];
        if (accept) begin
          grant[i]   = 1'b1;
          pushedData = reqData[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    push = accept;
  end

  // Arbiter FSM; state only moves on an accepted word, so a full queue freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (sel_lock) begin
            state_q <= StLocked;
            owner_q <= sel_idx;
          end else begin
            rr_ptr_q <= next_ptr;
          end
        end
        StLocked: begin
          if (!sel_lock) begin
            state_q  <= StIdle;
            rr_ptr_q <= next_ptr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign locked = (state_q == StLocked);
  assign owner  = owner_q;

endmodule
